// File: rtl/rcosc_div_pkg.sv
// Shared types and helpers for the RC-oscillator clock-divider bank.
package rcosc_div_pkg;

    localparam int DIV_W_DEF = 16;

    typedef enum logic [1:0] {
        PARKED = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2
    } chan_state_t;

    // A divisor of zero has no meaning; it is promoted to divide-by-one.
    function automatic logic [31:0] sanitise_div(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/rcosc_div_chan.sv
// One divider channel: period counter, pending divisor and glitch-free registered outputs.
module rcosc_div_chan
    import rcosc_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 160
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_out,
    output logic             tick,
    output logic [DIV_W-1:0] div_cur,
    output chan_state_t      state
);

    localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
    localparam logic [DIV_W:0]   ONE_H = (DIV_W + 1)'(1);

    chan_state_t      state_nx;
    logic [DIV_W-1:0] cnt, cnt_nx;
    logic [DIV_W-1:0] div_cur_nx;
    logic [DIV_W-1:0] pend, pend_nx;
    logic             pend_v, pend_v_nx;
    logic             div_out_nx, tick_nx;
    logic [DIV_W-1:0] div_san;
    logic [DIV_W:0]   half_d;
    logic             wrap;

    assign div_san = DIV_W'(sanitise_div(32'(div_val)));
    // One extra bit keeps (D+1)/2 exact for the largest divisor.
    assign half_d  = ({1'b0, div_cur} + ONE_H) >> 1;
    assign wrap    = (cnt == div_cur - ONE_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PARKED;
            cnt     <= '0;
            div_cur <= DIV_W'(DEF_DIV);
            pend    <= '0;
            pend_v  <= 1'b0;
            div_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            div_cur <= div_cur_nx;
            pend    <= pend_nx;
            pend_v  <= pend_v_nx;
            div_out <= div_out_nx;
            tick    <= tick_nx;
        end
    end

    // A write in the same cycle as a wrap bypasses pending so it governs the next period.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        div_cur_nx = div_cur;
        pend_nx    = pend;
        pend_v_nx  = pend_v;
        div_out_nx = 1'b0;
        tick_nx    = 1'b0;
        if (div_wr) begin
            pend_nx   = div_san;
            pend_v_nx = 1'b1;
        end
        case (state)
            PARKED: begin
                cnt_nx = '0;
                if (pend_v_nx) begin
                    div_cur_nx = pend_nx;
                    pend_v_nx  = 1'b0;
                end
                if (active) state_nx = RUN;
            end
            RUN, DRAIN: begin
                tick_nx    = (cnt == '0);
                div_out_nx = (div_cur != ONE_D) && ({1'b0, cnt} < half_d);
                if (wrap) begin
                    cnt_nx = '0;
                    if (pend_v_nx) begin
                        div_cur_nx = pend_nx;
                        pend_v_nx  = 1'b0;
                    end
                    state_nx = active ? RUN : PARKED;
                end else begin
                    cnt_nx   = cnt + ONE_D;
                    state_nx = active ? RUN : DRAIN;
                end
            end
            default: state_nx = PARKED;
        endcase
    end

endmodule

// File: rtl/rcosc_clk_divider.sv
// Clock-divider bank behind the 160 MHz RC oscillator: settle counter, READY, channel array.
module rcosc_clk_divider
    import rcosc_div_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DIV_W          = DIV_W_DEF,
    parameter int DEF_DIV        = 160,
    parameter int STARTUP_CYCLES = 64
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [NUM_CH-1:0]       CH_EN,
    input  logic [NUM_CH-1:0]       DIV_WR,
    input  logic [NUM_CH*DIV_W-1:0] DIV_VAL,
    output logic [NUM_CH-1:0]       DIV_OUT,
    output logic [NUM_CH-1:0]       TICK,
    output logic [NUM_CH*DIV_W-1:0] DIV_CUR,
    output logic                    READY,
    output logic [2*NUM_CH-1:0]     DBG_STATE
);

    localparam int               SET_W    = $clog2(STARTUP_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(STARTUP_CYCLES - 1);

    logic [SET_W-1:0] settle_cnt;

    // Counter freezes once READY is set; READY then holds until the next reset.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            settle_cnt <= '0;
            READY      <= 1'b0;
        end else if (!READY) begin
            if (settle_cnt == SET_LAST) READY <= 1'b1;
            settle_cnt <= settle_cnt + SET_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        chan_state_t ch_state;

        rcosc_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (CLK),
            .rst_n   (RESETN),
            .active  (READY & CH_EN[i]),
            .div_wr  (DIV_WR[i]),
            .div_val (DIV_VAL[i*DIV_W +: DIV_W]),
            .div_out (DIV_OUT[i]),
            .tick    (TICK[i]),
            .div_cur (DIV_CUR[i*DIV_W +: DIV_W]),
            .state   (ch_state)
        );

        assign DBG_STATE[2*i +: 2] = ch_state;
    end

endmodule

// File: tb/tb_rcosc_clk_divider.sv
// Bench for rcosc_clk_divider: period-level reference model plus directed scenarios.
module tb_rcosc_clk_divider;

    localparam int NUM_CH  = 4;
    localparam int DIV_W   = 16;
    localparam int DEF_DIV = 160;
    localparam int STARTUP = 64;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       div_wr;
    logic [NUM_CH*DIV_W-1:0] div_val;
    logic [NUM_CH-1:0]       div_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH*DIV_W-1:0] div_cur;
    logic                    ready;
    logic [2*NUM_CH-1:0]     dbg_state;

    rcosc_clk_divider #(
        .NUM_CH         (NUM_CH),
        .DIV_W          (DIV_W),
        .DEF_DIV        (DEF_DIV),
        .STARTUP_CYCLES (STARTUP)
    ) dut (
        .CLK       (clk),
        .RESETN    (rst_n),
        .CH_EN     (ch_en),
        .DIV_WR    (div_wr),
        .DIV_VAL   (div_val),
        .DIV_OUT   (div_out),
        .TICK      (tick),
        .DIV_CUR   (div_cur),
        .READY     (ready),
        .DBG_STATE (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is either idle or inside a period that began at edge m_start;
    // outputs follow from the offset into that period.
    int                m_d     [NUM_CH];
    int                m_pend  [NUM_CH];
    int                m_start [NUM_CH];
    bit                m_pv    [NUM_CH];
    bit                m_on    [NUM_CH];
    int                m_edge;
    int                m_settled;
    logic [NUM_CH-1:0] e_tick;
    logic [NUM_CH-1:0] e_out;
    logic              e_ready;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_d[i]     = DEF_DIV;
            m_pend[i]  = 0;
            m_start[i] = 0;
            m_pv[i]    = 1'b0;
            m_on[i]    = 1'b0;
        end
        m_edge    = 0;
        m_settled = 0;
        e_tick    = '0;
        e_out     = '0;
        e_ready   = 1'b0;
    endtask

    task automatic model_step();
        bit act;
        int v;
        int off;
        m_edge++;
        for (int i = 0; i < NUM_CH; i++) begin
            act = e_ready && ch_en[i];
            if (div_wr[i]) begin
                v         = int'(div_val[i*DIV_W +: DIV_W]);
                m_pend[i] = (v == 0) ? 1 : v;
                m_pv[i]   = 1'b1;
            end
            if (!m_on[i]) begin
                e_tick[i] = 1'b0;
                e_out[i]  = 1'b0;
                if (m_pv[i]) begin
                    m_d[i]  = m_pend[i];
                    m_pv[i] = 1'b0;
                end
                if (act) begin
                    m_on[i]    = 1'b1;
                    m_start[i] = m_edge + 1;
                end
            end else begin
                off       = m_edge - m_start[i];
                e_tick[i] = (off == 0);
                e_out[i]  = (m_d[i] > 1) && (2 * off < m_d[i]);
                if (off == m_d[i] - 1) begin
                    if (m_pv[i]) begin
                        m_d[i]  = m_pend[i];
                        m_pv[i] = 1'b0;
                    end
                    if (act) m_start[i] = m_edge + 1;
                    else     m_on[i]    = 1'b0;
                end
            end
        end
        m_settled++;
        if (m_settled >= STARTUP) e_ready = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- scoreboard: every cycle, away from the active edge ----------------
    always @(negedge clk) begin : cmp
        logic [NUM_CH*DIV_W-1:0] exp_cur;
        for (int i = 0; i < NUM_CH; i++) exp_cur[i*DIV_W +: DIV_W] = DIV_W'(m_d[i]);
        check("cyc_ready",   64'(ready),   64'(e_ready));
        check("cyc_tick",    64'(tick),    64'(e_tick));
        check("cyc_div_out", 64'(div_out), 64'(e_out));
        check("cyc_div_cur", 64'(div_cur), 64'(exp_cur));
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_div(input int ch, input int val);
        div_val[ch*DIV_W +: DIV_W] = DIV_W'(val);
        div_wr[ch] = 1'b1;
        step(1);
        div_wr[ch] = 1'b0;
    endtask

    task automatic wait_tick(input int ch, output int t);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (tick[ch]) begin
                t = cyc;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_tick ch%0d: no tick within 400 cycles, required one", ch);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : main
        int t0, t1, t2;
        int tk0, tk1, tk2, hi0, hi1, hi2;
        bit ok;
        logic [NUM_CH*DIV_W-1:0] def_cur;

        def_cur = {NUM_CH{DIV_W'(DEF_DIV)}};
        rst_n   = 1'b1;
        ch_en   = '1;
        div_wr  = '0;
        div_val = '0;
        #2 rst_n = 1'b0;
        step(3);

        check("rst_div_out",   64'(div_out),   64'd0);
        check("rst_tick",      64'(tick),      64'd0);
        check("rst_ready",     64'(ready),     64'd0);
        check("rst_div_cur",   64'(div_cur),   64'(def_cur));
        check("rst_dbg_state", 64'(dbg_state), 64'd0);

        rst_n = 1'b1;
        step(10);
        // Divisor writes during settle: ch1 -> 5, ch2 -> 0 (treated as 1)
        div_val[1*DIV_W +: DIV_W] = 16'd5;
        div_val[2*DIV_W +: DIV_W] = 16'd0;
        div_wr = 4'b0110;
        step(1);
        div_wr = '0;
        step(52);
        check("ready_at_63", 64'(ready), 64'd0);
        step(1);
        check("ready_at_64",      64'(ready),                     64'd1);
        check("quiet_tick_64",    64'(tick),                      64'd0);
        check("quiet_div_out_64", 64'(div_out),                   64'd0);
        check("ch1_div_cur_5",    64'(div_cur[1*DIV_W +: DIV_W]), 64'd5);
        check("ch2_div_cur_1",    64'(div_cur[2*DIV_W +: DIV_W]), 64'd1);

        tk0 = 0; tk1 = 0; tk2 = 0; hi0 = 0; hi1 = 0; hi2 = 0;
        for (int k = 0; k < 480; k++) begin
            step(1);
            tk0 += int'(tick[0]);    hi0 += int'(div_out[0]);
            tk1 += int'(tick[1]);    hi1 += int'(div_out[1]);
            tk2 += int'(tick[2]);    hi2 += int'(div_out[2]);
        end
        check("ch0_ticks_480", 64'(tk0), 64'd3);
        check("ch0_high_480",  64'(hi0), 64'd240);
        check("ch1_ticks_480", 64'(tk1), 64'd96);
        check("ch1_high_480",  64'(hi1), 64'd288);
        check("ch2_ticks_480", 64'(tk2), 64'd479);
        check("ch2_high_480",  64'(hi2), 64'd0);

        // ch0 to D=10, then write 4 mid-period at cnt=3
        set_div(0, 10);
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            step(1);
            ok = (div_cur[0 +: DIV_W] == 16'd10);
        end
        check("ch0_div10_applied", 64'(ok), 64'd1);
        wait_tick(0, t0);
        step(2);
        set_div(0, 4);
        check("ch0_no_mid_change", 64'(div_cur[0 +: DIV_W]), 64'd10);
        wait_tick(0, t1);
        wait_tick(0, t2);
        check("ival_finish_10", 64'(t1 - t0), 64'd10);
        check("ival_new_4",     64'(t2 - t1), 64'd4);

        // Write 6 on the wrap cycle of a D=4 period
        step(2);
        set_div(0, 6);
        wait_tick(0, t0);
        wait_tick(0, t1);
        check("ival_wrap_4", 64'(t0 - t2), 64'd4);
        check("ival_wrap_6", 64'(t1 - t0), 64'd6);

        // Drain: D=8, drop enable when cnt=2
        set_div(0, 8);
        wait_tick(0, t0);
        step(1);
        ch_en[0] = 1'b0;
        tk0 = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            tk0 += int'(tick[0]);
        end
        check("drain_no_tick",   64'(tk0),        64'd0);
        check("drain_parked_lo", 64'(div_out[0]), 64'd0);

        // Re-enable, drop at cnt=2, reassert at cnt=5: ticks must stay 8 apart
        ch_en[0] = 1'b1;
        wait_tick(0, t0);
        step(1);
        ch_en[0] = 1'b0;
        step(3);
        ch_en[0] = 1'b1;
        wait_tick(0, t1);
        wait_tick(0, t2);
        check("redrain_ival_1", 64'(t1 - t0), 64'd8);
        check("redrain_ival_2", 64'(t2 - t1), 64'd8);

        // Asynchronous reset in the middle of a period
        step(3);
        #3 rst_n = 1'b0;
        #1;
        check("async_div_out", 64'(div_out), 64'd0);
        check("async_tick",    64'(tick),    64'd0);
        check("async_ready",   64'(ready),   64'd0);
        check("async_div_cur", 64'(div_cur), 64'(def_cur));
        step(2);
        rst_n = 1'b1;
        step(70);
        check("ready_again", 64'(ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
